// File: rtl/lab2_proc_mem_responder.sv
// Test-memory responder: word-addressed storage behind a 2-entry response FIFO.
// Define LAB2_PROC_MEM_RESPONDER_STATS_EN to add num_reads/num_writes counters.
// reqstream_msg  = {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}
// respstream_msg = {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}

module lab2_proc_mem_responder #(
  parameter int unsigned p_mem_nwords = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [76:0] reqstream_msg,
  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [46:0] respstream_msg
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] num_reads,
  output logic [31:0] num_writes
`endif
);

  localparam int unsigned AW = $clog2(p_mem_nwords);

  logic [2:0]    req_type;
  logic [7:0]    req_opaque;
  logic [31:0]   req_addr;
  logic [1:0]    req_len;
  logic [31:0]   req_data;
  logic [AW-1:0] req_idx;
  logic          unused_addr_hi;

  assign req_type       = reqstream_msg[76:74];
  assign req_opaque     = reqstream_msg[73:66];
  assign req_addr       = reqstream_msg[65:34];
  assign req_len        = reqstream_msg[33:32];
  assign req_data       = reqstream_msg[31:0];
  assign req_idx        = req_addr[AW+1:2];
  // Upper address bits wrap modulo the storage size.
  assign unused_addr_hi = ^req_addr[31:AW+2];

  logic [31:0] mem_q [p_mem_nwords];

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [46:0] fifo_q [2];

  logic        accept;
  logic        consume;
  logic        is_read;
  logic        is_write;

  assign reqstream_rdy  = (count_q != 2'd2);
  assign respstream_val = (count_q != 2'd0);
  assign respstream_msg = fifo_q[rd_ptr_q];

  assign accept   = reqstream_val && reqstream_rdy && !reset;
  assign consume  = respstream_val && respstream_rdy;
  assign is_read  = (req_type == 3'd0);
  assign is_write = (req_type == 3'd1) || (req_type == 3'd2);

  // Byte-lane decode: lanes marks bytes touched, off is the lowest touched byte.
  logic [1:0]  off;
  logic [3:0]  lanes;
  logic [31:0] keep;
  logic [4:0]  sh;
  logic [31:0] rd_word;
  logic [31:0] rd_data;
  logic [31:0] wr_sh;
  logic [31:0] wr_word;
  logic [46:0] resp_new;

  always_comb begin
    off   = 2'd0;
    lanes = 4'b1111;
    keep  = 32'hffff_ffff;
    unique case (req_len)
      2'd0: begin
        off   = 2'd0;
        lanes = 4'b1111;
        keep  = 32'hffff_ffff;
      end
      2'd1: begin
        off   = req_addr[1:0];
        lanes = 4'b0001 << req_addr[1:0];
        keep  = 32'h0000_00ff;
      end
      2'd2: begin
        off   = {req_addr[1], 1'b0};
        lanes = 4'b0011 << {req_addr[1], 1'b0};
        keep  = 32'h0000_ffff;
      end
      default: begin
        off   = 2'd0;
        lanes = 4'b0111;
        keep  = 32'h00ff_ffff;
      end
    endcase
  end

  assign sh      = {off, 3'b000};
  assign rd_word = mem_q[req_idx];
  assign rd_data = (rd_word >> sh) & keep;
  assign wr_sh   = req_data << sh;

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) begin
        wr_word[8*b +: 8] = wr_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_new = {req_type, req_opaque, 2'b00, req_len, 32'd0};
    if (is_read) begin
      resp_new[31:0] = rd_data;
    end else if (!is_write) begin
      resp_new[35:34] = 2'b11;
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ consume;
    if (accept && !consume) begin
      count_d = count_q + 2'd1;
    end else if (!accept && consume) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage and FIFO payload are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= resp_new;
      if (is_write) begin
        mem_q[req_idx] <= wr_word;
      end
    end
  end

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
  logic [31:0] num_reads_q;
  logic [31:0] num_writes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_reads_q  <= 32'd0;
      num_writes_q <= 32'd0;
    end else begin
      if (accept && is_read) begin
        num_reads_q <= num_reads_q + 32'd1;
      end
      if (accept && is_write) begin
        num_writes_q <= num_writes_q + 32'd1;
      end
    end
  end

  assign num_reads  = num_reads_q;
  assign num_writes = num_writes_q;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Bench for lab2_proc_mem_responder: directed scenarios then random traffic,
// all responses checked against a byte-level memory model and an expected-response queue.

module tb_lab2_proc_mem_responder;

  localparam int NW = 256;

  logic        clk;
  logic        reset;
  logic        reqstream_val;
  logic        reqstream_rdy;
  logic [76:0] reqstream_msg;
  logic        respstream_val;
  logic        respstream_rdy;
  logic [46:0] respstream_msg;
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
  logic [31:0] num_reads;
  logic [31:0] num_writes;
`endif

  lab2_proc_mem_responder #(
    .p_mem_nwords(NW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reqstream_val (reqstream_val),
    .reqstream_rdy (reqstream_rdy),
    .reqstream_msg (reqstream_msg),
    .respstream_val(respstream_val),
    .respstream_rdy(respstream_rdy),
    .respstream_msg(respstream_msg)
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
    ,
    .num_reads     (num_reads),
    .num_writes    (num_writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          consumed = 0;
  int          n_reads  = 0;
  int          n_writes = 0;
  logic [31:0] mem_m [NW];
  logic [46:0] exp_q [$];
  logic [46:0] last_resp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [76:0] req(input logic [2:0] t, input logic [7:0] op,
                                      input logic [31:0] a, input logic [1:0] l,
                                      input logic [31:0] d);
    return {t, op, a, l, d};
  endfunction

  // Reference behaviour: which bytes a request touches, from the len rules.
  task automatic model_accept(input logic [76:0] m);
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] a;
    logic [1:0]  l;
    logic [31:0] d;
    logic [31:0] rdat;
    int          idx;
    int          first;
    int          n;
    t = m[76:74]; op = m[73:66]; a = m[65:34]; l = m[33:32]; d = m[31:0];
    idx = int'((a >> 2) % NW);
    case (l)
      2'd0: begin first = 0; n = 4; end
      2'd1: begin first = int'(a[1:0]); n = 1; end
      2'd2: begin first = a[1] ? 2 : 0; n = 2; end
      default: begin first = 0; n = 3; end
    endcase
    rdat = 32'd0;
    if (t == 3'd0) begin
      for (int k = 0; k < n; k++) rdat[8*k +: 8] = mem_m[idx][8*(first+k) +: 8];
      exp_q.push_back({t, op, 2'b00, l, rdat});
      n_reads++;
    end else if (t == 3'd1 || t == 3'd2) begin
      for (int k = 0; k < n; k++) mem_m[idx][8*(first+k) +: 8] = d[8*k +: 8];
      exp_q.push_back({t, op, 2'b00, l, 32'd0});
      n_writes++;
    end else begin
      exp_q.push_back({t, op, 2'b11, l, 32'd0});
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, update the model.
  task automatic step(input logic v, input logic [76:0] m, input logic r, output logic acc);
    reqstream_val  = v;
    reqstream_msg  = m;
    respstream_rdy = r;
    @(negedge clk);
    chk("req_rdy", reqstream_rdy, exp_q.size() != 2);
    chk("resp_val", respstream_val, exp_q.size() != 0);
    acc = v && reqstream_rdy;
    if (respstream_val && r) begin
      if (exp_q.size() != 0) begin
        chk("resp_msg", respstream_msg, exp_q[0]);
        void'(exp_q.pop_front());
      end
      last_resp = respstream_msg;
      consumed++;
    end
    if (acc) model_accept(m);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [76:0] m, input logic r);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, m, r, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, acc);
    chk("drained", exp_q.size(), 0);
    reqstream_val = 1'b0;
  endtask

  initial begin
    logic acc;
    int   c0;
    reset          = 1'b1;
    reqstream_val  = 1'b0;
    reqstream_msg  = '0;
    respstream_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", reqstream_rdy, 1'b1);
    chk("reset_val", respstream_val, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) send(req(3'd2, 8'(i), 32'(i * 4), 2'd0, $urandom), 1'b1);
    drain();

    // Write then read in back-to-back cycles.
    send(req(3'd1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF), 1'b1);
    send(req(3'd0, 8'h12, 32'h100, 2'd0, 32'h0), 1'b1);
    drain();
    chk("raw_data", last_resp[31:0], 32'hDEADBEEF);
    chk("raw_opaque", last_resp[43:36], 8'h12);

    // Backpressure: third request blocked until a response is consumed.
    send(req(3'd0, 8'h21, 32'h100, 2'd0, 32'h0), 1'b0);
    send(req(3'd0, 8'h22, 32'h000, 2'd1, 32'h0), 1'b0);
    step(1'b1, req(3'd0, 8'h23, 32'h004, 2'd2, 32'h0), 1'b0, acc);
    chk("third_blocked", acc, 1'b0);
    send(req(3'd0, 8'h23, 32'h004, 2'd2, 32'h0), 1'b1);
    drain();

    // Steady state with one entry: accept and consume every cycle.
    send(req(3'd0, 8'h30, 32'h100, 2'd0, 32'h0), 1'b0);
    c0 = consumed;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, req(3'd0, 8'(8'h31 + i), 32'(i * 4), 2'(i), 32'h0), 1'b1, acc);
      chk("steady_acc", acc, 1'b1);
    end
    chk("steady_consumed", consumed - c0, 10);
    drain();

    // Reset with two responses queued.
    send(req(3'd0, 8'h40, 32'h100, 2'd0, 32'h0), 1'b0);
    send(req(3'd1, 8'h41, 32'h008, 2'd0, 32'h0), 1'b0);
    reqstream_val = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_rdy", reqstream_rdy, 1'b1);
    chk("midrst_val", respstream_val, 1'b0);
    exp_q.delete();
    n_reads  = 0;
    n_writes = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(req(3'd0, 8'h42, 32'h100, 2'd0, 32'h0), 1'b1);
    drain();
    chk("post_rst_data", last_resp[31:0], 32'hDEADBEEF);

    // Sub-word accesses.
    send(req(3'd0, 8'h50, 32'h103, 2'd1, 32'h0), 1'b1);
    drain();
    chk("byte_rd", last_resp[31:0], 32'h000000DE);
    send(req(3'd0, 8'h51, 32'h102, 2'd2, 32'h0), 1'b1);
    drain();
    chk("half_rd", last_resp[31:0], 32'h0000DEAD);
    send(req(3'd1, 8'h52, 32'h101, 2'd1, 32'h55), 1'b1);
    send(req(3'd0, 8'h53, 32'h100, 2'd0, 32'h0), 1'b1);
    drain();
    chk("byte_wr", last_resp[31:0], 32'hDEAD55EF);

    // Address wrap and unknown type.
    send(req(3'd1, 8'h60, 32'h100 + 32'(4 * NW), 2'd0, 32'h12345678), 1'b1);
    send(req(3'd0, 8'h61, 32'h100, 2'd0, 32'h0), 1'b1);
    drain();
    chk("wrap_rd", last_resp[31:0], 32'h12345678);
    send(req(3'd5, 8'h62, 32'h100, 2'd0, 32'hFFFFFFFF), 1'b1);
    drain();
    chk("bad_test", last_resp[35:34], 2'b11);
    chk("bad_data", last_resp[31:0], 32'h0);
    send(req(3'd0, 8'h63, 32'h100, 2'd0, 32'h0), 1'b1);
    drain();
    chk("bad_nowrite", last_resp[31:0], 32'h12345678);

    // Random traffic over the initialised words, random upper address bits.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  t;
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      t = (sel < 4) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 8) ? 3'd2 : (sel == 8) ? 3'd5 : 3'd7;
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, req(t, 8'($urandom), a, 2'($urandom), $urandom),
           $urandom_range(0, 2) != 0, acc);
    end
    drain();

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
    chk("num_reads", num_reads, 32'(n_reads));
    chk("num_writes", num_writes, 32'(n_writes));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab2_proc_mem_responder.md
LAB2_PROC_MEM_RESPONDER -- requirements
Module: lab2_proc_mem_responder

Interface
REQ-001 SHALL have parameter p_mem_nwords, default 256, words of backing storage (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port reqstream_val  input  1  request valid.
REQ-005 SHALL have port reqstream_rdy  output  1  request ready.
REQ-006 SHALL have port reqstream_msg  input  mem_req_4B_t  fields type(3) opaque(8) addr(32) len(2) data(32).
REQ-007 SHALL have port respstream_val  output  1  response valid.
REQ-008 SHALL have port respstream_rdy  input  1  response ready.
REQ-009 SHALL have port respstream_msg  output  mem_resp_4B_t  fields type(3) opaque(8) test(2) len(2) data(32).

Function
REQ-010 SHALL treat a request as accepted in a cycle when reqstream_val and reqstream_rdy are both high at the rising edge.
REQ-011 SHALL treat a response as consumed when respstream_val and respstream_rdy are both high at the rising edge.
REQ-012 SHALL hold responses in a 2-entry FIFO; reqstream_rdy = (count != 2), respstream_val = (count != 0), both purely combinational from count.
REQ-013 SHALL deliver each response one cycle after acceptance at minimum (no combinational req-to-resp path).
REQ-014 SHALL keep responses in acceptance order; count +1 on accept only, -1 on consume only, unchanged on both.
REQ-015 SHALL hold respstream_msg stable while respstream_val high and respstream_rdy low.
REQ-016 SHALL index storage with addr[log2(p_mem_nwords)+1:2]; upper address bits ignored (wrap modulo storage size).
REQ-017 SHALL interpret len: 0 = 4 bytes (addr[1:0] ignored), 1 = byte at addr[1:0], 2 = halfword at addr[1] (addr[0] ignored), 3 = 3 bytes at addr[1:0]=0.
REQ-018 SHALL on read (type 0) return selected bytes zero-extended in data[LSBs], echo type, opaque, len, test = 0.
REQ-019 SHALL on write (type 1) or init (type 2) update only the selected bytes from data LSBs at the accepting edge; response data = 0, type echoed.
REQ-020 SHALL make a write visible to any request accepted on a later edge (read-after-write in consecutive cycles returns new data).
REQ-021 SHALL on any other type leave storage unchanged and respond with data = 0, test = 2'b11.

Reset
REQ-022 SHALL on reset assertion immediately clear count and FIFO pointers: reqstream_rdy = 1, respstream_val = 0.
REQ-023 SHALL discard in-flight responses when reset asserts mid-operation; respstream_msg value is don't-care while respstream_val = 0.
REQ-024 SHALL not clear storage contents on reset; storage is undefined until written.

Configuration
REQ-025 SHALL, with LAB2_PROC_MEM_RESPONDER_STATS_EN defined, add outputs num_reads and num_writes (32-bit each) counting accepted type-0 and type-1/2 requests, reset to 0, wrapping at 2^32.
REQ-026 SHALL, without LAB2_PROC_MEM_RESPONDER_STATS_EN, omit those ports and counters entirely, with identical handshake behaviour.

Verification
REQ-027 Write 0xDEADBEEF addr 0x100 len 0, then read addr 0x100 len 0 next cycle -> responses type 1 data 0, then type 0 data 0xDEADBEEF, opaques echoed.
REQ-028 After REQ-027, read addr 0x103 len 1 -> data 0x000000DE; read addr 0x102 len 2 -> 0x0000DEAD; write byte 0x55 at 0x101 then word read -> 0xDEAD55EF.
REQ-029 respstream_rdy = 0, three back-to-back requests -> first two accepted, reqstream_rdy low on third; raise rdy -> third accepted next cycle, order preserved.
REQ-030 count = 1 with simultaneous accept and consume for 10 cycles -> count stays 1, rdy and val stay high, one response per cycle.
REQ-031 Assert reset with two responses queued -> respstream_val 0 and reqstream_rdy 1 before next edge; prior word at 0x100 still reads 0xDEADBEEF after reset.
REQ-032 Write addr 0x100 + 4*p_mem_nwords, read addr 0x100 -> wrapped data returned; type 5 request -> test 2'b11, data 0; with STATS_EN counters match accepted reads/writes.
